port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter.sv | 138 +++++++++++++
 tb/tb_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Round-robin output arbiter for one destination port: picks one eligible flit
// per cycle into a single-entry output register that can drain and refill together.

// Per-requester eligibility: a flit requests this port only if it is valid,
// carries the valid marker and is addressed here.
module port_arbiter_req #(
  parameter int PortAddr     = 0,
  parameter int AddressWidth = 3
) (
  input  logic                    i_valid,
  input  logic                    i_vmark,
  input  logic [AddressWidth-1:0] i_dest,
  output logic                    o_req
);
  assign o_req = i_valid & i_vmark & (i_dest == AddressWidth'(PortAddr));
endmodule

module port_arbiter #(
  parameter int PortAddr     = 0,
  parameter int NumIn        = 8,
  parameter int AddressWidth = 3,
  parameter int DataWidth    = 38
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumIn*DataWidth-1:0] i_data,
  input  logic [NumIn-1:0]           i_valid,
  output logic [NumIn-1:0]           o_ready,
  output logic [DataWidth-1:0]       o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_grant_count,
  output logic                       o_busy
);
  localparam int PtrW = (NumIn > 1) ? $clog2(NumIn) : 1;

  typedef struct packed {
    logic                               vmark;
    logic                               head;
    logic [AddressWidth-1:0]            dest;
    logic [DataWidth-AddressWidth-3:0]  rest;
  } flit_t;

  typedef enum logic {EMPTY, FULL} state_e;

  flit_t [NumIn-1:0] flits;
  logic  [NumIn-1:0] req;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  win_found;
  logic [PtrW-1:0]       win_idx;
  logic [PtrW:0]         sum;
  logic                  load_en;
  logic                  grant;

  assign flits = i_data;

  for (genvar k = 0; k < NumIn; k++) begin : g_req
    port_arbiter_req #(
      .PortAddr     (PortAddr),
      .AddressWidth (AddressWidth)
    ) u_req (
      .i_valid (i_valid[k]),
      .i_vmark (flits[k].vmark),
      .i_dest  (flits[k].dest),
      .o_req   (req[k])
    );
  end

  // First request at or above ptr, wrapping; index built modulo NumIn so
  // non-power-of-two requester counts wrap correctly.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 0; i < NumIn; i++) begin
      sum = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NumIn)) sum = sum - (PtrW+1)'(NumIn);
      if (!win_found && req[sum[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PtrW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (i_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Grant is masked by rst so o_ready stays quiet while reset is held.
  always_comb begin
    load_en = (state_q == EMPTY) | i_ready;
    grant   = load_en & win_found & ~rst;
    o_ready = grant ? (NumIn'(1) << win_idx) : '0;
    o_valid = (state_q == FULL);
    o_busy  = o_valid;
  end

  always_comb begin
    data_d = data_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (grant) begin
      data_d = flits[win_idx];
      ptr_d  = (win_idx == PtrW'(NumIn-1)) ? '0 : win_idx + PtrW'(1);
      cnt_d  = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data        = data_q;
  assign o_grant_count = cnt_q;
endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: a reference model predicts grants and the
// output register; directed scenarios plus a random phase.
module tb_port_arbiter;
  localparam int NumIn = 8;
  localparam int DW    = 38;
  localparam int AW    = 3;
  localparam int PA    = 0;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NumIn*DW-1:0]   i_data;
  logic [NumIn-1:0]      i_valid;
  logic [NumIn-1:0]      o_ready;
  logic [DW-1:0]         o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [31:0]           o_grant_count;
  logic                  o_busy;

  port_arbiter #(.PortAddr(PA), .NumIn(NumIn), .AddressWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_grant_count(o_grant_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] fl [NumIn];
  logic [DW-1:0] sb [$];
  int            dut_grants [$];
  logic          m_full;
  int            m_ptr;
  logic [31:0]   m_cnt;
  logic          seen5;
  logic [2:0]    pa_v;
  logic [DW-1:0] exp_d;
  logic [31:0]   exp_c;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic mark, input logic [2:0] dest, input logic [31:0] pl);
    return {mark, 1'b1, dest, 1'b0, pl};
  endfunction

  task automatic apply();
    for (int k = 0; k < NumIn; k++) i_data[k*DW +: DW] = fl[k];
  endtask

  task automatic model_clear();
    m_full = 1'b0;
    m_ptr  = 0;
    m_cnt  = '0;
    sb.delete();
  endtask

  // Called just after a falling edge with inputs applied; checks and advances the model.
  task automatic step();
    int            win;
    logic [NumIn-1:0] exp_rdy;
    logic [DW-1:0] f;
    #1;
    chk("o_valid", o_valid, m_full);
    chk("o_busy", o_busy, m_full);
    chk("count", o_grant_count, m_cnt);
    if (m_full) chk("o_data", o_data, sb[0]);
    win = -1;
    if (!m_full || i_ready) begin
      for (int j = 0; j < NumIn; j++) begin
        int k;
        k = (m_ptr + j) % NumIn;
        f = i_data[k*DW +: DW];
        if (win < 0 && i_valid[k] && f[37] && f[35:33] == pa_v) win = k;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("o_ready", o_ready, exp_rdy);
    seen5 = seen5 | o_ready[5];
    for (int k = 0; k < NumIn; k++) if (o_ready[k]) dut_grants.push_back(k);
    if (m_full && i_ready) begin
      void'(sb.pop_front());
      m_full = 1'b0;
    end
    if (win >= 0) begin
      sb.push_back(i_data[win*DW +: DW]);
      m_full = 1'b1;
      m_ptr  = (win + 1) % NumIn;
      m_cnt  = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    pa_v    = 3'(PA);
    seen5   = 1'b0;
    rst     = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < NumIn; k++) fl[k] = mk(1'b1, 3'd0, 32'h100 + k);
    apply();
    i_valid = '1;
    model_clear();
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_cnt", o_grant_count, 0);
    @(negedge clk);
    rst = 1'b0;
    i_valid = '0;

    // lone requester 3
    fl[3] = mk(1'b1, 3'd0, 32'hA5A5_0003);
    apply();
    i_valid = 8'h08;
    dut_grants.delete();
    step();
    chk("s1_valid", o_valid, 1);
    chk("s1_data", o_data, mk(1'b1, 3'd0, 32'hA5A5_0003));
    chk("s1_cnt", o_grant_count, 1);
    chk("s1_ngrant", dut_grants.size(), 1);
    if (dut_grants.size() > 0) chk("s1_win", dut_grants[0], 3);
    i_valid = '0;
    step();
    chk("drain_valid", o_valid, 0);

    // all eight requesting, 16 cycles
    do_reset();
    for (int k = 0; k < NumIn; k++) fl[k] = mk(1'b1, 3'd0, 32'h200 + k);
    apply();
    i_valid = '1;
    dut_grants.delete();
    repeat (16) step();
    chk("rr_ngrant", dut_grants.size(), 16);
    for (int i = 0; i < 16 && i < dut_grants.size(); i++) chk("rr_order", dut_grants[i], i % 8);
    chk("rr_cnt", o_grant_count, 16);
    i_valid = '0;
    step();

    // requester 5 addressed elsewhere
    do_reset();
    fl[2] = mk(1'b1, 3'd0, 32'h0000_0022);
    fl[5] = mk(1'b1, 3'd1, 32'h0000_0055);
    apply();
    i_valid = 8'h24;
    seen5 = 1'b0;
    dut_grants.delete();
    repeat (4) step();
    chk("dest_r5", seen5, 0);
    chk("dest_ngrant", dut_grants.size(), 4);
    for (int i = 0; i < dut_grants.size(); i++) chk("dest_win", dut_grants[i], 2);
    i_valid = '0;
    step();

    // back-pressure hold then reload
    for (int k = 0; k < NumIn; k++) fl[k] = mk(1'b1, 3'd0, 32'h300 + k);
    apply();
    i_valid = '1;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    exp_d = sb[0];
    exp_c = m_cnt;
    repeat (5) begin
      step();
      chk("hold_rdy", o_ready, 0);
      chk("hold_data", o_data, exp_d);
      chk("hold_cnt", o_grant_count, exp_c);
    end
    i_ready = 1'b1;
    #1;
    chk("reload_rdy", |o_ready, 1);
    step();
    chk("reload_cnt", o_grant_count, exp_c + 32'd1);
    chk("reload_valid", o_valid, 1);

    // drain with nothing requesting
    i_valid = '0;
    step();
    chk("drain2_valid", o_valid, 0);

    // reset while FULL with ptr at 5
    do_reset();
    for (int k = 0; k < NumIn; k++) fl[k] = mk(1'b1, 3'd0, 32'h400 + k);
    apply();
    i_valid = 8'h10;
    i_ready = 1'b1;
    step();
    i_valid = '0;
    i_ready = 1'b0;
    step();
    chk("pre_rst_valid", o_valid, 1);
    rst = 1'b1;
    i_valid = '1;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_cnt", o_grant_count, 0);
    chk("mid_rst_rdy", o_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    i_ready = 1'b1;
    dut_grants.delete();
    step();
    chk("post_rst_ngrant", dut_grants.size(), 1);
    if (dut_grants.size() > 0) chk("post_rst_win", dut_grants[0], 0);

    // random traffic against the model
    repeat (400) begin
      for (int k = 0; k < NumIn; k++)
        fl[k] = mk(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 1)), $urandom);
      apply();
      i_valid = NumIn'($urandom);
      i_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
